vec3_normalize_pipeline: RTL and testbench
==========================================

Name: vec3_normalize_pipeline

Overview:
- Streaming normaliser for Q8.24 3-vectors, used for ray directions and surface normals.
- Computes s = x²+y²+z² and hands s to the external inverse-square-root pipeline over a request/response port pair.
- Holds the components in an internal FIFO while the root is in flight, then multiplies each component by the returned 1/√s.
- Fully pipelined at one vector per clock; no backpressure anywhere.

Parameters:
- FRAC, 24, fractional bits of the Q8.24 format
- FIFO_DEPTH, 64, in-flight component store entries; must exceed the isqrt latency plus 8
- SMALL_THRESH, 1024, raw value of s below which the vector is degenerate

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input vector strobe
- in_x, in_y, in_z  in  32 each  signed Q8.24 components
- isqrt_a  out  32  signed Q8.24 sum of squares, to the isqrt pipeline
- isqrt_new_data  out  1  strobe qualifying isqrt_a
- isqrt_r  in  32  signed Q8.24 1/√s from the isqrt pipeline
- isqrt_valid  in  1  strobe qualifying isqrt_r; responses arrive in request order
- out_valid  out  1  result strobe
- out_x, out_y, out_z  out  32 each  signed Q8.24 normalised components
- out_degenerate  out  1  result came from a degenerate vector and is forced to zero
- err_sat  out  1  sticky: s saturated
- err_fifo  out  1  sticky: FIFO overflow, or a response arrived with the FIFO empty

Behaviour:
- Reset values: all outputs 0, FIFO emptied, sticky flags cleared. Reset aborts in-flight data. Isqrt responses arriving after reset hit an empty FIFO, set err_fifo and are dropped; the system resets both blocks together.
- Fixed multiply, used everywhere: full 64-bit signed product, result = product[55:24], i.e. arithmetic shift right by FRAC, truncation toward -inf.
- Front pipe, latency 3 from in_valid to isqrt_new_data:
  - F1 registers the inputs.
  - F2 registers x², y², z² (each ≥ 0).
  - F3 registers the 34-bit sum. If the sum exceeds 0x7FFFFFFF, isqrt_a = 0x7FFFFFFF and err_sat is set.
- FIFO push happens at F3 valid. Entry = {x, y, z, degenerate}, where degenerate = (s < SMALL_THRESH), raw compare on the saturated s.
- FIFO is synchronous with 6-bit pointers plus a wrap bit.
  - Push when full: entry dropped, err_fifo set, isqrt_new_data still issued.
  - Push and pop in the same cycle: both occur and the count is unchanged, including at full and at empty.
- Back pipe, starts on isqrt_valid:
  - Pop the head entry. If the FIFO is empty, set err_fifo and produce no output.
  - B1 registers the entry and isqrt_r.
  - B2 registers the three products, then out_valid pulses for one cycle.
  - If degenerate, out_x/y/z = 0 and out_degenerate = 1.
- Latency: in_valid to out_valid = 3 + L_isqrt + 2, which is 35 with the standard 30-cycle isqrt.
- Outputs hold their last value when out_valid = 0.
- Sticky flags clear only on rst.
- Back-to-back inputs on every clock must produce back-to-back outputs in order.

Decomposition:
- Shared package: Q_FRAC = 24, Q_ONE = 32'h01000000, Q_MAX = 32'h7FFFFFFF, and the fixed-multiply slice function.
- One sub-module: sync_fifo (parameterised width and depth, with full/empty/count), instantiated with width 97.
- Multipliers are inline, registered.

Test Plan:
- x = 3.0 (0x03000000), y = 4.0, z = 0; bench returns isqrt_r = 0x00333333 when isqrt_new_data is seen with isqrt_a = 0x19000000 → out = (0x00999999, 0x00CCCCCC, 0), out_degenerate = 0.
- x = 1.0, y = z = 0; response isqrt_r = 0x01000000 → isqrt_a = 0x01000000, out = (0x01000000, 0, 0).
- x = 12.0, y = z = 0 → isqrt_a = 0x7FFFFFFF, err_sat = 1 and stays 1 until rst.
- x = y = z = 0x00000010 → s = 0 → out = (0, 0, 0), out_degenerate = 1.
- 40 consecutive vectors with isqrt latency 30 → 40 ordered results on consecutive cycles, FIFO count never above 34, err_fifo = 0.
- Assert isqrt_valid with nothing outstanding → err_fifo = 1, no out_valid. Then rst mid-stream → all outputs 0 next cycle, later responses do not produce out_valid.

Source files
------------

// File: rtl/vec3_normalize_pipeline_pkg.sv
// vec3_normalize_pipeline_pkg: Q8.24 constants, FIFO entry layout and fixed-point multiply helpers
package vec3_normalize_pipeline_pkg;
    localparam int          Q_FRAC = 24;
    localparam logic [31:0] Q_ONE  = 32'h0100_0000;
    localparam logic [31:0] Q_MAX  = 32'h7FFF_FFFF;
    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] z;
        logic               degenerate;
    } entry_t;
    function automatic logic signed [31:0] qmul(input logic signed [31:0] a, input logic signed [31:0] b, input int frac = Q_FRAC);
        logic signed [63:0] p;
        p = 64'(a) * 64'(b);
        return 32'(p >>> frac);
    endfunction
    function automatic logic [31:0] qsq(input logic signed [31:0] a);
        logic signed [63:0] p;
        p = 64'(a) * 64'(a);
        return p >= (64'(Q_ONE) << 32) ? '1 : 32'(p >>> Q_FRAC);
    endfunction
endpackage

// File: rtl/vec3_normalize_pipeline_sync_fifo.sv
// vec3_normalize_pipeline_sync_fifo: single-clock FIFO where a simultaneous push and pop always both happen
module vec3_normalize_pipeline_sync_fifo #(
    parameter int WIDTH = 97,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr, count;
    logic             do_push, do_pop;
    assign count   = wptr - rptr;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && (!empty || push);
    assign rdata   = empty ? wdata : mem[rptr[AW-1:0]];
    // pointer update; the wrap bit separates full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop) rptr <= rptr + (AW+1)'(1);
        end
    end
    // storage write, no reset needed since pointers gate every read
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/vec3_normalize_pipeline.sv
// vec3_normalize_pipeline: streams Q8.24 vectors through sum-of-squares, external 1/sqrt and rescale
module vec3_normalize_pipeline
    import vec3_normalize_pipeline_pkg::*;
#(
    parameter int FRAC         = 24,
    parameter int FIFO_DEPTH   = 64,
    parameter int SMALL_THRESH = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic signed [31:0] in_x,
    input  logic signed [31:0] in_y,
    input  logic signed [31:0] in_z,
    output logic        [31:0] isqrt_a,
    output logic               isqrt_new_data,
    input  logic signed [31:0] isqrt_r,
    input  logic               isqrt_valid,
    output logic               out_valid,
    output logic signed [31:0] out_x,
    output logic signed [31:0] out_y,
    output logic signed [31:0] out_z,
    output logic               out_degenerate,
    output logic               err_sat,
    output logic               err_fifo
);
    logic               v1, v2, b1;
    logic signed [31:0] x1, y1, z1, x2, y2, z2, x3, y3, z3, r1;
    logic        [31:0] sx, sy, sz;
    logic        [33:0] sum;
    logic               fifo_full, fifo_empty;
    entry_t             push_e, head, e1;
    assign sum    = 34'(sx) + 34'(sy) + 34'(sz);
    assign push_e = '{x: x3, y: y3, z: z3, degenerate: isqrt_a < 32'(SMALL_THRESH)};
    vec3_normalize_pipeline_sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (isqrt_new_data),
        .pop   (isqrt_valid),
        .wdata (push_e),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
    // front pipe: register inputs, square, then sum with saturation into the isqrt request
    always_ff @(posedge clk) begin
        if (rst) begin
            {v1, v2, isqrt_new_data, err_sat} <= '0;
            {x1, y1, z1, x2, y2, z2, x3, y3, z3} <= '0;
            {sx, sy, sz, isqrt_a} <= '0;
        end else begin
            v1             <= in_valid;
            {x1, y1, z1}   <= {in_x, in_y, in_z};
            v2             <= v1;
            {x2, y2, z2}   <= {x1, y1, z1};
            sx             <= qsq(x1);
            sy             <= qsq(y1);
            sz             <= qsq(z1);
            isqrt_new_data <= v2;
            {x3, y3, z3}   <= {x2, y2, z2};
            isqrt_a        <= sum > 34'(Q_MAX) ? Q_MAX : sum[31:0];
            err_sat        <= err_sat | (v2 && sum > 34'(Q_MAX));
        end
    end
    // back pipe: capture popped entry with its root, then scale; outputs hold between results
    always_ff @(posedge clk) begin
        if (rst) begin
            {b1, out_valid, out_degenerate, err_fifo} <= '0;
            {e1, r1, out_x, out_y, out_z} <= '0;
        end else begin
            b1             <= isqrt_valid && (!fifo_empty || isqrt_new_data);
            e1             <= head;
            r1             <= isqrt_r;
            out_valid      <= b1;
            err_fifo       <= err_fifo | (isqrt_new_data && fifo_full && !isqrt_valid)
                                       | (isqrt_valid && fifo_empty && !isqrt_new_data);
            if (b1) begin
                out_x          <= e1.degenerate ? '0 : qmul(e1.x, r1, FRAC);
                out_y          <= e1.degenerate ? '0 : qmul(e1.y, r1, FRAC);
                out_z          <= e1.degenerate ? '0 : qmul(e1.z, r1, FRAC);
                out_degenerate <= e1.degenerate;
            end
        end
    end
endmodule

// File: tb/tb_vec3_normalize_pipeline.sv
// tb_vec3_normalize_pipeline: directed and random vectors against an arithmetic reference with a modelled isqrt
module tb_vec3_normalize_pipeline;
    localparam int L = 30;
    logic               clk = 0, rst = 1, in_valid = 0, isqrt_valid = 0;
    logic signed [31:0] in_x = 0, in_y = 0, in_z = 0, isqrt_r = 0;
    logic        [31:0] isqrt_a;
    logic               isqrt_new_data, out_valid, out_degenerate, err_sat, err_fifo;
    logic signed [31:0] out_x, out_y, out_z;
    typedef struct {int due; int a; int x; int y; int z; bit deg; bit drop;} item_t;
    item_t req_q[$], resp_q[$], exp_q[$];
    int cyc = 0, n_assert = 0, n_fail = 0, max_cnt = 0;

    always #5 clk = ~clk;

    vec3_normalize_pipeline dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .isqrt_a(isqrt_a), .isqrt_new_data(isqrt_new_data), .isqrt_r(isqrt_r), .isqrt_valid(isqrt_valid),
        .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_z(out_z),
        .out_degenerate(out_degenerate), .err_sat(err_sat), .err_fifo(err_fifo)
    );

    function automatic longint sq(int v);
        return (longint'(v) * longint'(v)) >>> 24;
    endfunction

    function automatic int qm(int a, int b);
        longint p;
        p = longint'(a) * longint'(b);
        return int'(p >>> 24);
    endfunction

    function automatic int isqrt_ref(int a);
        real v;
        if (a <= 0) return 32'h7FFFFFFF;
        v = 68719476736.0 / $sqrt(real'(a));
        if (v >= 2147483647.0) return 32'h7FFFFFFF;
        return $rtoi(v);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(int x, int y, int z);
        longint s;
        int a;
        s = sq(x) + sq(y) + sq(z);
        if (s > 64'sh7FFFFFFF) a = 32'h7FFFFFFF;
        else a = int'(s);
        in_valid = 1; in_x = x; in_y = y; in_z = z;
        req_q.push_back('{due: cyc + 3, a: a, x: x, y: y, z: z, deg: a < 1024, drop: 0});
    endtask

    task automatic step();
        item_t it;
        bit want;
        int r;
        @(negedge clk);
        cyc++;
        in_valid = 0;
        isqrt_valid = 0;
        want = req_q.size() > 0 && req_q[0].due == cyc;
        chk("isqrt_new_data", 32'(isqrt_new_data), 32'(want));
        if (want) begin
            it = req_q.pop_front();
            chk("isqrt_a", isqrt_a, it.a);
            it.due = cyc + L;
            resp_q.push_back(it);
        end
        want = exp_q.size() > 0 && exp_q[0].due == cyc;
        chk("out_valid", 32'(out_valid), 32'(want));
        if (want) begin
            it = exp_q.pop_front();
            r = isqrt_ref(it.a);
            chk("out_x", out_x, it.deg ? 0 : qm(it.x, r));
            chk("out_y", out_y, it.deg ? 0 : qm(it.y, r));
            chk("out_z", out_z, it.deg ? 0 : qm(it.z, r));
            chk("out_degenerate", 32'(out_degenerate), 32'(it.deg));
        end
        if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
        if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
            it = resp_q.pop_front();
            isqrt_valid = 1;
            isqrt_r = isqrt_ref(it.a);
            if (!it.drop) begin
                it.due = cyc + 2;
                exp_q.push_back(it);
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (req_q.size() + resp_q.size() + exp_q.size()) > 0; i++) step();
        chk("drain_done", 32'(req_q.size() + resp_q.size() + exp_q.size()), 0);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_isqrt_a"}, isqrt_a, 0);
        chk({tag, "_isqrt_new_data"}, 32'(isqrt_new_data), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_x"}, out_x, 0);
        chk({tag, "_out_y"}, out_y, 0);
        chk({tag, "_out_z"}, out_z, 0);
        chk({tag, "_out_degenerate"}, 32'(out_degenerate), 0);
        chk({tag, "_err_sat"}, 32'(err_sat), 0);
        chk({tag, "_err_fifo"}, 32'(err_fifo), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        repeat (3) step();
        chk_zero("reset");
        rst = 0;
        step();
        send(32'h03000000, 32'h04000000, 0);
        drain();
        chk("v345_x", out_x, 32'h00999999);
        chk("v345_y", out_y, 32'h00CCCCCC);
        chk("v345_z", out_z, 0);
        chk("v345_deg", 32'(out_degenerate), 0);
        send(32'h01000000, 0, 0);
        drain();
        chk("unit_x", out_x, 32'h01000000);
        chk("unit_y", out_y, 0);
        chk("no_sat_yet", 32'(err_sat), 0);
        send(32'h0C000000, 0, 0);
        drain();
        chk("sat_flag", 32'(err_sat), 1);
        send(32'h10, 32'h10, 32'h10);
        drain();
        chk("degen_flag", 32'(out_degenerate), 1);
        chk("degen_x", out_x, 0);
        max_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            send(int'($urandom) >>> $urandom_range(4, 9), int'($urandom) >>> $urandom_range(4, 9),
                 int'($urandom) >>> $urandom_range(4, 9));
            step();
        end
        drain();
        chk("stream_fifo_peak_ok", 32'(max_cnt <= 34), 1);
        chk("stream_err_fifo", 32'(err_fifo), 0);
        chk("sat_sticky", 32'(err_sat), 1);
        isqrt_valid = 1;
        isqrt_r = 32'h01000000;
        step();
        step();
        chk("underflow_err_fifo", 32'(err_fifo), 1);
        chk("underflow_no_out", 32'(out_valid), 0);
        for (int i = 0; i < 10; i++) begin
            send(int'($urandom) >>> 6, int'($urandom) >>> 6, int'($urandom) >>> 6);
            step();
        end
        repeat (5) step();
        rst = 1;
        req_q.delete();
        exp_q.delete();
        foreach (resp_q[i]) resp_q[i].drop = 1;
        step();
        chk_zero("midreset");
        rst = 0;
        drain();
        chk("post_reset_err_fifo", 32'(err_fifo), 1);
        chk("post_reset_no_out", 32'(out_valid), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
